// File: rtl/stack_prog_seq.sv
// ---------------------------------------------------------------------------
// stack_prog_seq
//
// Program sequencer for the stack calculator. It holds a loadable program of
// (opcode, immediate) words and, on start, walks through it, issuing one
// stack operation every two cycles (FETCH decodes, EXEC pulses apply). It
// tracks the stack depth itself and watches the live stack head, so faulting
// operations are stopped before they reach the stack.
//
// Optional feature macro: STACK_SEQ_GUARD_EN
//   defined   : underflow, overflow and divide-by-zero checks are active.
//   undefined : only illegal opcodes fault; every legal opcode is forwarded
//               and depth saturates at 0 and at SDEPTH.
//
// Opcodes: 0 inc, 1 dec, 2 add, 3 sub, 4 mul, 5 div, 6 mod, 7 push imm,
//          8 pop, 15 HALT (never forwarded), 9..14 illegal.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset, shared with the stack
//   ld_we     in   program write strobe (ignored while busy)
//   ld_addr   in   program write address
//   ld_op     in   opcode to store
//   ld_imm    in   immediate to store (used by push only)
//   start     in   begin execution at pc 0 (ignored while busy)
//   head      in   stack top value fed back from the stack
//   op        out  opcode to the stack (registered)
//   in        out  push operand to the stack (registered)
//   apply     out  stack executes op at the edge where this is 1 (registered)
//   busy      out  sequencer is in FETCH or EXEC
//   done      out  halted normally, held until next start
//   err       out  halted on a fault, held until next start
//   err_code  out  0 underflow, 1 overflow, 2 divide by zero, 3 illegal
//   pc        out  program counter; on a fault, address of the faulting word
//   depth     out  tracked stack depth
// ---------------------------------------------------------------------------
module stack_prog_seq #(
  parameter int W      = 16,
  parameter int PDEPTH = 16,
  parameter int PAW    = 4,
  parameter int SDEPTH = 8,
  localparam int DW    = $clog2(SDEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld_we,
  input  logic [PAW-1:0] ld_addr,
  input  logic [3:0]     ld_op,
  input  logic [W-1:0]   ld_imm,
  input  logic           start,
  input  logic [W-1:0]   head,
  output logic [3:0]     op,
  output logic [W-1:0]   in,
  output logic           apply,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [1:0]     err_code,
  output logic [PAW-1:0] pc,
  output logic [DW-1:0]  depth
);

  // Opcode encodings.
  localparam logic [3:0] OP_INC  = 4'd0;
  localparam logic [3:0] OP_DEC  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_MOD  = 4'd6;
  localparam logic [3:0] OP_PUSH = 4'd7;
  localparam logic [3:0] OP_POP  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  // Fault codes.
  localparam logic [1:0] ERR_UNDERFLOW = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_DIVZERO   = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

  localparam logic [PAW-1:0] PC_LAST   = PAW'(PDEPTH - 1);
  localparam logic [DW-1:0]  DEPTH_MAX = DW'(SDEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DONE,
    S_ERR
  } state_t;

  state_t state;

  // Program store, split into opcode and immediate fields.
  logic [3:0]   prog_op  [PDEPTH];
  logic [W-1:0] prog_imm [PDEPTH];

  // Decode of the word at pc, used in FETCH.
  logic [3:0]   f_op;
  logic [W-1:0] f_imm;
  logic         f_halt;
  logic         f_fault;
  logic [1:0]   f_code;

  // Depth after the operation currently held in op commits.
  logic [DW-1:0] depth_next;

  // -------------------------------------------------------------------------
  // Program memory. Loads are accepted only while not busy; a load in the
  // same cycle as start lands at that edge, ahead of the first FETCH.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the program array is reset on purpose: every word must read as
      // HALT after reset, so a start on an unloaded sequencer halts at once.
      for (int i = 0; i < PDEPTH; i++) begin
        prog_op[i]  <= OP_HALT;
        prog_imm[i] <= '0;
      end
    end else if (ld_we && !busy) begin
      prog_op[ld_addr]  <= ld_op;
      prog_imm[ld_addr] <= ld_imm;
    end
  end

  // -------------------------------------------------------------------------
  // FETCH decode and fault detection. Precedence: illegal opcode, then depth
  // preconditions, then divide by zero. head already reflects the previous
  // EXEC because the stack commits on that closing edge.
  // -------------------------------------------------------------------------
`ifdef STACK_SEQ_GUARD_EN
  logic f_need1;
  logic f_need2;
  logic f_push;
  logic f_divide;
`else
  // head only matters to the divide-by-zero check.
  logic unused_head;
  assign unused_head = ^head;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave one unassigned and infer a latch.
    f_op    = prog_op[pc];
    f_imm   = prog_imm[pc];
    f_halt  = (f_op == OP_HALT);
    f_fault = 1'b0;
    f_code  = ERR_UNDERFLOW;
`ifdef STACK_SEQ_GUARD_EN
    f_need1  = (f_op == OP_INC) || (f_op == OP_DEC) || (f_op == OP_POP);
    f_need2  = (f_op >= OP_ADD) && (f_op <= OP_MOD);
    f_push   = (f_op == OP_PUSH);
    f_divide = (f_op == OP_DIV) || (f_op == OP_MOD);
`endif
    if ((f_op > OP_POP) && (f_op < OP_HALT)) begin
      f_fault = 1'b1;
      f_code  = ERR_ILLEGAL;
    end
`ifdef STACK_SEQ_GUARD_EN
    else if ((f_need1 && (depth == '0)) || (f_need2 && (depth < DW'(2)))) begin
      f_fault = 1'b1;
      f_code  = ERR_UNDERFLOW;
    end else if (f_push && (depth >= DEPTH_MAX)) begin
      f_fault = 1'b1;
      f_code  = ERR_OVERFLOW;
    end else if (f_divide && (head == '0)) begin
      f_fault = 1'b1;
      f_code  = ERR_DIVZERO;
    end
`endif
  end

  // -------------------------------------------------------------------------
  // Depth effect of the operation in flight. Saturation only matters when
  // the guard is off; with it on, FETCH never lets depth leave its range.
  // -------------------------------------------------------------------------
  always_comb begin
    depth_next = depth;
    if (op == OP_PUSH) begin
      if (depth < DEPTH_MAX) depth_next = depth + 1'b1;
    end else if (((op >= OP_ADD) && (op <= OP_MOD)) || (op == OP_POP)) begin
      if (depth != '0) depth_next = depth - 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM. All outputs are registered here, so apply/op/in reach the
  // stack glitch-free and apply drops asynchronously with rst.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      depth    <= '0;
      op       <= '0;
      in       <= '0;
      err_code <= '0;
      apply    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      apply <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            pc    <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (f_halt) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (f_fault) begin
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= f_code;
            state    <= S_ERR;
          end else begin
            op    <= f_op;
            in    <= (f_op == OP_PUSH) ? f_imm : '0;
            apply <= 1'b1;
            state <= S_EXEC;
          end
        end

        S_EXEC: begin
          // The stack commits op on this same edge; mirror its depth change.
          depth <= depth_next;
          pc    <= pc + 1'b1;
          if (pc == PC_LAST) begin
            // Running off the end of the program behaves like HALT.
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_FETCH;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_prog_seq.sv
// ---------------------------------------------------------------------------
// tb_stack_prog_seq
//
// Directed bench for stack_prog_seq. A small behavioural stack calculator
// closes the head feedback loop: binary ops take the second entry as the
// left operand and the top as the right (a - b, a / b, a % b). Expected
// results are hand-computed constants. Inputs change and outputs are sampled
// on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_stack_prog_seq;

  localparam int W      = 16;
  localparam int PAW    = 4;
  localparam int SDEPTH = 8;
  localparam int DW     = $clog2(SDEPTH) + 1;

  logic           clk;
  logic           rst;
  logic           ld_we;
  logic [PAW-1:0] ld_addr;
  logic [3:0]     ld_op;
  logic [W-1:0]   ld_imm;
  logic           start;
  logic [W-1:0]   head;
  logic [3:0]     op;
  logic [W-1:0]   in;
  logic           apply;
  logic           busy;
  logic           done;
  logic           err;
  logic [1:0]     err_code;
  logic [PAW-1:0] pc;
  logic [DW-1:0]  depth;

  stack_prog_seq #(.W(W), .PDEPTH(16), .PAW(PAW), .SDEPTH(SDEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_we    (ld_we),
    .ld_addr  (ld_addr),
    .ld_op    (ld_op),
    .ld_imm   (ld_imm),
    .start    (start),
    .head     (head),
    .op       (op),
    .in       (in),
    .apply    (apply),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .pc       (pc),
    .depth    (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural stack ----------------
  logic [W-1:0] stk [0:31];
  int           sp;
  int           apply_total = 0;
  logic [W-1:0] tos;
  logic [W-1:0] nos;
  logic [W-1:0] res;
  int           bi;

  assign head = (sp > 0) ? stk[sp-1] : '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= 0;
    end else if (apply) begin
      apply_total <= apply_total + 1;
      tos = (sp >= 1) ? stk[sp-1] : '0;
      nos = (sp >= 2) ? stk[sp-2] : '0;
      bi  = (sp >= 2) ? sp - 2 : 0;
      case (op)
        4'd2: res = nos + tos;
        4'd3: res = nos - tos;
        4'd4: res = nos * tos;
        4'd5: res = (tos == '0) ? '0 : nos / tos;
        4'd6: res = (tos == '0) ? '0 : nos % tos;
        default: res = '0;
      endcase
      case (op)
        4'd0: if (sp > 0) stk[sp-1] <= tos + 1'b1;
        4'd1: if (sp > 0) stk[sp-1] <= tos - 1'b1;
        4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
          stk[bi] <= res;
          if (sp >= 2) sp <= sp - 1;
        end
        4'd7: if (sp < 32) begin
          stk[sp] <= in;
          sp      <= sp + 1;
        end
        4'd8: if (sp > 0) sp <= sp - 1;
        default: ;
      endcase
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // ---------------- stimulus helpers ----------------
  int n_apply;
  int first_apply;
  int gap_bad;
  int base;
  int start_busy;
  int start_flags;

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic load(input int addr, input int opc, input int imm);
    ld_we   = 1'b1;
    ld_addr = PAW'(addr);
    ld_op   = 4'(opc);
    ld_imm  = W'(imm);
    @(negedge clk);
    ld_we   = 1'b0;
  endtask

  // Sample from the first FETCH cycle until done or err, bounded.
  task automatic wait_end(input string tag, input int max_cyc);
    int last_c;
    int ended;
    last_c      = -1;
    ended       = 0;
    first_apply = -1;
    gap_bad     = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (apply) begin
        if (first_apply < 0) first_apply = c;
        else if (c - last_c != 2) gap_bad++;
        last_c = c;
      end
      if (done || err) begin
        ended = 1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_ended"}, ended, 1);
    n_apply = apply_total - base;
  endtask

  task automatic run_prog(input string tag, input int max_cyc);
    base  = apply_total;
    start = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    ld_we       = 1'b0;
    start_busy  = int'(busy);
    start_flags = int'(done | err);
    wait_end(tag, max_cyc);
  endtask

  initial begin
    rst     = 1'b1;
    ld_we   = 1'b0;
    ld_addr = '0;
    ld_op   = '0;
    ld_imm  = '0;
    start   = 1'b0;
    do_reset();

    // ---- reset state ----
    check("rst_busy",  int'(busy), 0);
    check("rst_done",  int'(done), 0);
    check("rst_err",   int'(err), 0);
    check("rst_apply", int'(apply), 0);
    check("rst_pc",    int'(pc), 0);
    check("rst_depth", int'(depth), 0);
    check("rst_op",    int'(op), 0);
    check("rst_in",    int'(in), 0);
    check("rst_code",  int'(err_code), 0);
    // Unloaded program is all HALT.
    run_prog("empty", 20);
    check("empty_done",  int'(done), 1);
    check("empty_apply", n_apply, 0);
    check("empty_pc",    int'(pc), 0);

    // ---- basic run: 300 % 7 = 6 ----
    do_reset();
    load(0, 7, 300);
    load(1, 7, 7);
    load(2, 6, 0);
    run_prog("basic", 40);
    check("basic_busy0",  start_busy, 1);
    check("basic_napply", n_apply, 3);
    check("basic_first",  first_apply, 1);
    check("basic_gap",    gap_bad, 0);
    check("basic_done",   int'(done), 1);
    check("basic_err",    int'(err), 0);
    check("basic_head",   int'(head), 6);
    check("basic_depth",  int'(depth), 1);
    check("basic_pc",     int'(pc), 3);
    repeat (3) @(negedge clk);
    check("basic_hold",   int'(done), 1);

    // ---- full arithmetic run ----
    // [300,150,2] add->[300,152] mul->[45600] /152->[300] -5->[295] +5->[300]
    // push 9, pop, inc, dec -> [300]. Ends on the reset HALT at address 15.
    do_reset();
    load(0, 7, 300);
    load(1, 7, 150);
    load(2, 7, 2);
    load(3, 2, 0);
    load(4, 4, 0);
    load(5, 7, 152);
    load(6, 5, 0);
    load(7, 7, 5);
    load(8, 3, 0);
    load(9, 7, 5);
    load(10, 2, 0);
    load(11, 7, 9);
    load(12, 8, 0);
    load(13, 0, 0);
    load(14, 1, 0);
    run_prog("arith", 80);
    check("arith_napply", n_apply, 15);
    check("arith_done",   int'(done), 1);
    check("arith_head",   int'(head), 300);
    check("arith_depth",  int'(depth), 1);
    check("arith_pc",     int'(pc), 15);

    // ---- add on an empty stack ----
    do_reset();
    load(0, 2, 0);
    run_prog("under", 20);
`ifdef STACK_SEQ_GUARD_EN
    check("under_err",    int'(err), 1);
    check("under_code",   int'(err_code), 0);
    check("under_pc",     int'(pc), 0);
    check("under_napply", n_apply, 0);
`else
    check("under_done",   int'(done), 1);
    check("under_napply", n_apply, 1);
    check("under_pc",     int'(pc), 1);
    check("under_depth",  int'(depth), 0);
`endif

    // ---- divide by zero: push 5, push 0, div ----
    do_reset();
    load(0, 7, 5);
    load(1, 7, 0);
    load(2, 5, 0);
    run_prog("div0", 30);
`ifdef STACK_SEQ_GUARD_EN
    check("div0_napply", n_apply, 2);
    check("div0_err",    int'(err), 1);
    check("div0_code",   int'(err_code), 2);
    check("div0_pc",     int'(pc), 2);
    check("div0_depth",  int'(depth), 2);
`else
    check("div0_napply", n_apply, 3);
    check("div0_done",   int'(done), 1);
    check("div0_pc",     int'(pc), 3);
    check("div0_depth",  int'(depth), 1);
`endif

    // ---- overflow: nine pushes into an 8-deep stack ----
    do_reset();
    for (int i = 0; i < 9; i++) load(i, 7, i + 1);
    run_prog("ovf", 40);
`ifdef STACK_SEQ_GUARD_EN
    check("ovf_err",    int'(err), 1);
    check("ovf_code",   int'(err_code), 1);
    check("ovf_pc",     int'(pc), 8);
    check("ovf_napply", n_apply, 8);
`else
    check("ovf_done",   int'(done), 1);
    check("ovf_napply", n_apply, 9);
    check("ovf_pc",     int'(pc), 9);
`endif
    check("ovf_depth", int'(depth), 8);

    // ---- illegal opcode, then restart from ERR ----
    do_reset();
    load(0, 7, 1);
    load(1, 12, 0);
    run_prog("ill", 20);
    check("ill_err",    int'(err), 1);
    check("ill_code",   int'(err_code), 3);
    check("ill_pc",     int'(pc), 1);
    check("ill_napply", n_apply, 1);
    run_prog("ill2", 20);
    check("ill2_clear", start_flags, 0);
    check("ill2_depth", int'(depth), 2);
    check("ill2_code",  int'(err_code), 3);

    // ---- wrap: 16 incs with no HALT, depth 1 carried over ----
    do_reset();
    load(0, 7, 7);
    run_prog("seed", 20);
    for (int i = 0; i < 15; i++) load(i, 0, 0);
    // Last word is written in the same cycle as start.
    ld_we   = 1'b1;
    ld_addr = PAW'(15);
    ld_op   = 4'd0;
    ld_imm  = '0;
    run_prog("wrap", 60);
    check("wrap_napply", n_apply, 16);
    check("wrap_done",   int'(done), 1);
    check("wrap_pc",     int'(pc), 0);
    check("wrap_depth",  int'(depth), 1);
    check("wrap_head",   int'(head), 23);

    // ---- load and start lockout while busy ----
    do_reset();
    load(0, 7, 1);
    load(1, 7, 2);
    load(2, 7, 3);
    base  = apply_total;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    ld_we   = 1'b1;
    ld_addr = PAW'(1);
    ld_op   = 4'd8;
    ld_imm  = W'(99);
    @(negedge clk);
    @(negedge clk);
    ld_we = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("lock", 30);
    check("lock_napply", n_apply, 3);
    check("lock_head",   int'(head), 3);
    run_prog("lock2", 30);
    check("lock2_head",  int'(head), 3);
    check("lock2_depth", int'(depth), 6);

    // ---- reset during EXEC ----
    do_reset();
    load(0, 7, 1);
    load(1, 7, 2);
    load(2, 7, 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_apply", int'(apply), 1);
    check("mid_pc",    int'(pc), 1);
    check("mid_depth", int'(depth), 1);
    rst = 1'b1;
    #1;
    check("arst_apply", int'(apply), 0);
    check("arst_busy",  int'(busy), 0);
    check("arst_pc",    int'(pc), 0);
    check("arst_depth", int'(depth), 0);
    check("arst_op",    int'(op), 0);
    check("arst_in",    int'(in), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_prog("post", 20);
    check("post_napply", n_apply, 0);
    check("post_done",   int'(done), 1);
    check("post_pc",     int'(pc), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
